// File: rtl/lfsr_pkg.sv
// Shared constants for the 3-bit XNOR/NAND pattern generator and its checker.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 3;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 3'b000;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Tap-select masks, tested in priority order XNOR20, XNOR10, NAND21
    localparam logic [2:0] MODE_XNOR_20 = 3'b101;
    localparam logic [2:0] MODE_XNOR_10 = 3'b011;
    localparam logic [2:0] MODE_NAND_21 = 3'b110;

endpackage

// File: rtl/lfsr_feedback.sv
// Feedback tap logic shared by the pattern generator and the checker.
module lfsr_feedback
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] s,
    input  logic [2:0]        mode,
    output logic              fb
);

    always_comb begin
        fb = ~(s[2] ^ s[0]);
        if ((mode & MODE_XNOR_20) == MODE_XNOR_20) begin
            fb = ~(s[2] ^ s[0]);
        end else if ((mode & MODE_XNOR_10) == MODE_XNOR_10) begin
            fb = ~(s[1] ^ s[0]);
        end else if ((mode & MODE_NAND_21) == MODE_NAND_21) begin
            fb = ~(s[2] & s[1]);
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising receive checker for the 3-bit LFSR pattern stream.
// Define LFSR_CHK_BITCNT_EN to build the locked-bit counter behind bit_count.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic [2:0]       mode,
    input  logic             err_clear,
    output logic             locked,
    output logic             bit_err,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] bit_count
);

    logic [1:0]        state;
    logic [LFSR_W-1:0] s;
    logic [2:0]        mode_q;
    logic [1:0]        fill_cnt;
    logic [3:0]        match_cnt;
    logic [3:0]        miss_cnt;
    logic              fb;
    logic              mode_chg;
    logic              mispredict;
    logic              err_evt;

    lfsr_feedback u_feedback (
        .s    (s),
        .mode (mode),
        .fb   (fb)
    );

    assign mode_chg   = (mode != mode_q);
    assign mispredict = (bit_in != fb);
    assign err_evt    = bit_valid && !mode_chg && (state == ST_LOCKED) && mispredict;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_SEARCH;
            s         <= LFSR_SEED;
            mode_q    <= mode;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            bit_err   <= 1'b0;
        end else begin
            mode_q  <= mode;
            locked  <= (state == ST_LOCKED);
            bit_err <= err_evt;
            if (mode_chg) begin
                state     <= ST_SEARCH;
                fill_cnt  <= '0;
                match_cnt <= '0;
                miss_cnt  <= '0;
            end else if (bit_valid) begin
                case (state)
                    ST_SEARCH: begin
                        s <= {s[1:0], bit_in};
                        if (fill_cnt == 2'd2) begin
                            fill_cnt <= '0;
                            state    <= ST_VERIFY;
                        end else begin
                            fill_cnt <= fill_cnt + 2'd1;
                        end
                    end
                    ST_VERIFY: begin
                        // Re-seeding from the input makes a mismatch self-correcting
                        s <= {s[1:0], bit_in};
                        if (mispredict) begin
                            match_cnt <= '0;
                        end else if (match_cnt == 4'(LOCK_CNT - 1)) begin
                            match_cnt <= '0;
                            state     <= ST_LOCKED;
                        end else begin
                            match_cnt <= match_cnt + 4'd1;
                        end
                    end
                    ST_LOCKED: begin
                        s <= {s[1:0], fb};
                        if (!mispredict) begin
                            miss_cnt <= '0;
                        end else if (miss_cnt == 4'(LOSS_CNT - 1)) begin
                            miss_cnt <= '0;
                            fill_cnt <= '0;
                            state    <= ST_SEARCH;
                        end else begin
                            miss_cnt <= miss_cnt + 4'd1;
                        end
                    end
                    default: state <= ST_SEARCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || err_clear) begin
            err_count <= '0;
        end else if (err_evt && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

`ifdef LFSR_CHK_BITCNT_EN
    logic cnt_evt;
    assign cnt_evt = bit_valid && !mode_chg && (state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (!reset || err_clear) begin
            bit_count <= '0;
        end else if (cnt_evt && (bit_count != '1)) begin
            bit_count <= bit_count + 1'b1;
        end
    end
`else
    assign bit_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker with a per-cycle behavioural reference.
module tb_lfsr_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int ERR_W    = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             bit_in;
    logic             bit_valid;
    logic [2:0]       mode;
    logic             err_clear;
    logic             locked;
    logic             bit_err;
    logic [ERR_W-1:0] err_count;
    logic [ERR_W-1:0] bit_count;

    always #5 clk = ~clk;

    lfsr_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .ERR_W    (ERR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .mode      (mode),
        .err_clear (err_clear),
        .locked    (locked),
        .bit_err   (bit_err),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Generator rule written straight from the tap table
    function automatic logic pat_fb(input logic [2:0] st, input logic [2:0] md);
        if (md[2] && md[0])      return !(st[2] ^ st[0]);
        else if (md[1] && md[0]) return !(st[1] ^ st[0]);
        else if (md[2] && md[1]) return !(st[2] && st[1]);
        else                     return !(st[2] ^ st[0]);
    endfunction

    // Reference: phase 0 = hunting, 1 = verifying, 2 = locked
    int               m_phase;
    int               m_seen;
    int               m_good;
    int               m_bad;
    logic [2:0]       m_s;
    logic [2:0]       m_mode_prev;
    logic             exp_locked;
    logic             exp_err;
    logic [ERR_W-1:0] exp_cnt;
    logic [ERR_W-1:0] exp_bits;

    always @(posedge clk) begin
        logic pred;
        logic e;
        logic counted;
        if (!reset) begin
            m_phase = 0; m_seen = 0; m_good = 0; m_bad = 0; m_s = 3'b000;
            m_mode_prev = mode;
            exp_locked = 1'b0; exp_err = 1'b0; exp_cnt = '0; exp_bits = '0;
        end else begin
            e = 1'b0;
            counted = 1'b0;
            exp_locked = (m_phase == 2);
            if (mode != m_mode_prev) begin
                m_phase = 0; m_seen = 0; m_good = 0; m_bad = 0;
            end else if (bit_valid) begin
                pred = pat_fb(m_s, mode);
                if (m_phase == 0) begin
                    m_s = {m_s[1:0], bit_in};
                    m_seen++;
                    if (m_seen == 3) begin m_seen = 0; m_phase = 1; end
                end else if (m_phase == 1) begin
                    m_s = {m_s[1:0], bit_in};
                    if (bit_in == pred) begin
                        m_good++;
                        if (m_good == LOCK_CNT) begin m_good = 0; m_phase = 2; end
                    end else begin
                        m_good = 0;
                    end
                end else begin
                    counted = 1'b1;
                    m_s = {m_s[1:0], pred};
                    if (bit_in != pred) begin
                        e = 1'b1;
                        m_bad++;
                        if (m_bad == LOSS_CNT) begin m_bad = 0; m_seen = 0; m_phase = 0; end
                    end else begin
                        m_bad = 0;
                    end
                end
            end
            m_mode_prev = mode;
            exp_err = e;
            if (err_clear) begin
                exp_cnt = '0; exp_bits = '0;
            end else begin
                if (e && exp_cnt != {ERR_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
                if (counted && exp_bits != {ERR_W{1'b1}}) exp_bits = exp_bits + 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("locked", 32'(locked), 32'(exp_locked));
            check("bit_err", 32'(bit_err), 32'(exp_err));
            check("err_count", 32'(err_count), 32'(exp_cnt));
`ifdef LFSR_CHK_BITCNT_EN
            check("bit_count", 32'(bit_count), 32'(exp_bits));
`else
            check("bit_count", 32'(bit_count), 32'd0);
`endif
        end
    end

    logic [2:0] g;

    task automatic step(input logic b, input logic v);
        bit_in    = b;
        bit_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_send(input logic flip, input logic v);
        logic b;
        if (v) begin
            b = pat_fb(g, mode);
            g = {g[1:0], b};
            step(b ^ flip, 1'b1);
        end else begin
            step(1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        reset = 1'b0; mode = 3'b101; bit_in = 1'b0; bit_valid = 1'b0; err_clear = 1'b0;
        g = 3'b000;
        step(1'b0, 1'b0);
        chk_on = 1'b1;
        step(1'b1, 1'b1);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_bit_err", 32'(bit_err), 32'd0);
        reset = 1'b1;

        // Clean 101 stream: 1,0,1,1,0,0,0 ...
        for (int i = 0; i < 7; i++) gen_send(1'b0, 1'b1);
        check("lock_not_yet", 32'(locked), 32'd0);
        gen_send(1'b0, 1'b1);
        check("lock_rise", 32'(locked), 32'd1);
        for (int i = 0; i < 92; i++) gen_send(1'b0, 1'b1);
        check("clean_100_errs", 32'(err_count), 32'd0);
`ifdef LFSR_CHK_BITCNT_EN
        check("clean_100_bits", 32'(bit_count), 32'd93);
`endif

        gen_send(1'b1, 1'b1);
        check("single_err_pulse", 32'(bit_err), 32'd1);
        gen_send(1'b0, 1'b1);
        check("single_err_gone", 32'(bit_err), 32'd0);
        for (int i = 0; i < 8; i++) gen_send(1'b0, 1'b1);
        check("single_err_count", 32'(err_count), 32'd1);
        check("single_err_locked", 32'(locked), 32'd1);

        for (int i = 0; i < 3; i++) gen_send(1'b1, 1'b1);
        check("burst_err_count", 32'(err_count), 32'd4);
        check("burst_still_locked", 32'(locked), 32'd1);
        gen_send(1'b0, 1'b1);
        check("burst_lock_drop", 32'(locked), 32'd0);
        for (int i = 0; i < 6; i++) gen_send(1'b0, 1'b1);
        check("relock_not_yet", 32'(locked), 32'd0);
        gen_send(1'b0, 1'b1);
        check("relock", 32'(locked), 32'd1);

        // Stretched stream: each valid bit followed by an idle cycle
        reset = 1'b0;
        step(1'b0, 1'b0);
        reset = 1'b1;
        g = 3'b000;
        for (int i = 0; i < 6; i++) begin
            gen_send(1'b0, 1'b1);
            gen_send(1'b0, 1'b0);
        end
        gen_send(1'b0, 1'b1);
        check("gap_lock_not_yet", 32'(locked), 32'd0);
        gen_send(1'b0, 1'b0);
        check("gap_lock_rise", 32'(locked), 32'd1);
        gen_send(1'b1, 1'b1);
        check("gap_err_pulse", 32'(bit_err), 32'd1);
        gen_send(1'b0, 1'b0);
        check("gap_idle_no_err", 32'(bit_err), 32'd0);
        check("gap_err_count", 32'(err_count), 32'd1);

        // Mode switch while locked; the switching cycle's bit is discarded
        mode = 3'b011;
        step(1'b0, 1'b1);
        check("mode_chg_lag", 32'(locked), 32'd1);
        g = 3'b000;
        gen_send(1'b0, 1'b1);
        check("mode_chg_drop", 32'(locked), 32'd0);
        for (int i = 0; i < 6; i++) gen_send(1'b0, 1'b1);
        gen_send(1'b0, 1'b1);
        check("mode_relock", 32'(locked), 32'd1);

        err_clear = 1'b1;
        gen_send(1'b1, 1'b1);
        err_clear = 1'b0;
        check("clear_wins", 32'(err_count), 32'd0);
        check("clear_pulse", 32'(bit_err), 32'd1);

        mode  = 3'b101;
        reset = 1'b0;
        step(1'b1, 1'b1);
        reset = 1'b1;
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_bit_err", 32'(bit_err), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        check("midrst_bit_count", 32'(bit_count), 32'd0);

        // Stuck-at-one generator under XNOR taps
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        check("ones_locked", 32'(locked), 32'd1);
        check("ones_no_err", 32'(err_count), 32'd0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the 3-bit XNOR/NAND LFSR pattern generator.
- Consumes the serial pattern stream, self-synchronises a local 3-bit LFSR copy to it, then flywheels and flags bit errors.
- Sits at the far end of the test link (board loopback or pins) and drives lock/error LEDs and an error counter for BER bring-up.

Parameters:
LOCK_CNT, 4, consecutive correct predictions in VERIFY required to declare lock (1..15)
LOSS_CNT, 3, consecutive mispredictions in LOCKED that drop lock (1..15)
ERR_W, 16, width of error counter (and bit counter, when enabled)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
bit_in  input  1  received pattern bit
bit_valid  input  1  bit_in qualifier; checker state advances only when high
mode  input  3  tap select, same encoding as generator chooseTwo
err_clear  input  1  synchronous clear of err_count (and bit_count)
locked  output  1  high while in LOCKED
bit_err  output  1  one-cycle pulse per mispredicted valid bit while LOCKED
err_count  output  ERR_W  saturating count of bit_err pulses
bit_count  output  ERR_W  valid bits seen while LOCKED; constant 0 unless LFSR_CHK_BITCNT_EN

Behaviour:
- Reset (reset==0 at posedge):
  - state=SEARCH; shift reg s=3'b000; fill/match/miss counters 0.
  - locked=0, bit_err=0, err_count=0, bit_count=0.
  - Reset mid-operation discards all sync progress.
- Feedback fb(s), matching the generator exactly:
  - mode[2]&mode[0]: !(s[2]^s[0])
  - else mode[1]&mode[0]: !(s[1]^s[0])
  - else mode[2]&mode[1]: !(s[2]&s[1])
  - else: !(s[2]^s[0])
  - Predicted bit = fb(s). Generator stream = its new LSB each shift.
- No cycle with bit_valid==0 changes s, counters or state; bit_err is 0 that cycle.
- SEARCH: each valid bit: s <= {s[1:0],bit_in}, fill++. At 3rd valid bit: fill=0, go VERIFY.
- VERIFY: each valid bit: compare bit_in to fb(s); s <= {s[1:0],bit_in}.
  - Match: match++. Reaching LOCK_CNT -> LOCKED, match=0.
  - Mismatch: match=0, stay in VERIFY (s already re-seeded from input). No bit_err.
- LOCKED (flywheel): each valid bit: s <= {s[1:0],fb(s)}; input never loads s.
  - Mismatch: bit_err=1 next cycle, err_count++ (saturates at all-ones), miss++.
  - Match: miss=0.
  - miss reaching LOSS_CNT -> SEARCH, fill=0. The LOSS_CNT-th error is still counted.
- Outputs are registered: locked = (state==LOCKED) one cycle after the transition edge; bit_err likewise one cycle late.
- Mode change: mode is registered (mode_q). mode != mode_q in any state forces SEARCH with fill/match/miss=0. The bit arriving in that same cycle is ignored for comparison.
- err_clear: err_count (and bit_count) <= 0. Clear wins over a simultaneous error/bit; that event is not counted. bit_err pulse is still emitted.
- An all-ones state under XNOR modes (stuck generator) is legal. A constant-1 stream locks, and err_count stays 0.

Optional Feature:
LFSR_CHK_BITCNT_EN
- Defined: bit_count increments on each valid bit while LOCKED (including errored bits), saturating, cleared by err_clear/reset. Software derives BER = err_count/bit_count.
- Undefined: counter not built; bit_count tied to 0. Port list unchanged.

Decomposition:
- Package lfsr_pkg:
  - state encoding (SEARCH, VERIFY, LOCKED)
  - mode decode constants
  - LFSR width constant 3
  - generator reset seed 3'b000
- Sub-module lfsr_feedback (combinational: s, mode -> fb). Shared with the generator so both ends use identical tap logic.

Test Plan:
- Generator stream with mode=3'b101 from seed 000, i.e. 1,0,1,1,0,0,0 repeating, bit_valid=1 every cycle -> locked rises 1 cycle after the 7th bit (3 fill + 4 matches); err_count=0 over 100 bits.
- Locked, invert one bit -> exactly one bit_err pulse, err_count=1, locked stays 1, no further errors (flywheel).
- Locked, invert 3 consecutive bits -> err_count=3, locked falls 1 cycle after the 3rd errored bit. Clean stream thereafter -> relock after 7 valid bits.
- bit_valid toggled 1-0-1 with the same stream -> identical lock/error results, only stretched in time; idle cycles produce no bit_err.
- Locked, change mode to 3'b011 -> locked falls next cycle. Feed the 3'b011 generator stream -> relock after 7 valid bits.
- err_clear asserted in the same cycle as an errored bit -> err_count=0 afterwards, bit_err still pulses. reset=0 mid-lock -> all outputs 0 next cycle.
